// File: rtl/cd32_bus_pkg.sv
// Shared types and constants for the CD32 riser bus initiator.
package cd32_bus_pkg;

    typedef enum logic [2:0] {
        IDLE, ARB, ADDR, STROBE, WAIT, LATCH, RELEASE, FINISH
    } state_t;

    localparam logic [1:0] DSACK_NONE = 2'b11;
    localparam logic [1:0] DSACK_BYTE = 2'b10;
    localparam logic [7:0] RTC_BASE   = 8'hDC;

    // States in which we own the bus (BGACK asserted, address/RW driven).
    function automatic logic is_master(input state_t s);
        return s inside {ADDR, STROBE, WAIT, LATCH, RELEASE};
    endfunction

endpackage

// File: rtl/cd32_sync.sv
// Multi-stage synchroniser for asynchronous bus inputs; resets to RST_VAL.
module cd32_sync #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] pipe;

    always_ff @(posedge clk) begin
        if (!rst_n) pipe <= {STAGES{RST_VAL}};
        else        pipe <= {pipe[STAGES-2:0], d};
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/cd32_bus_initiator.sv
// 68020 async byte-cycle initiator for the CD32 riser: arbitrates, runs one
// read/write cycle, returns data/status. Define BUS_TIMEOUT_EN for a WAIT timeout.
module cd32_bus_initiator
    import cd32_bus_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int SETUP_CYCLES   = 1
) (
    input  logic        CLKCPU_A,
    input  logic        RESET_N,
    input  logic        REQ,
    input  logic        REQ_RW,
    input  logic [23:0] REQ_ADDR,
    input  logic [7:0]  REQ_WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [7:0]  RDATA,
    output logic        BR_N,
    input  logic        BG_N,
    output logic        BGACK_N,
    input  logic        AS20_N,
    output logic        AS_OUT_N,
    output logic        DS_OUT_N,
    output logic        RW_OUT,
    output logic [23:0] A_OUT,
    inout  wire  [7:0]  D,
    output logic        BUS_OE,
    input  logic [1:0]  DSACK_N
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("SYNC_STAGES must be 2..3");
    end
    if (SETUP_CYCLES < 1 || SETUP_CYCLES > 3) begin : g_bad_setup
        $error("SETUP_CYCLES must be 1..3");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 8-bit counter");
    end

    localparam logic [1:0] SETUP_LAST = 2'(SETUP_CYCLES - 1);

    state_t      state, state_nxt;
    logic        rw_q;
    logic [23:0] addr_q;
    logic [7:0]  wdata_q;
    logic [1:0]  setup_cnt;
    logic        d_oe;
    logic        bg_s, as20_s;
    logic [1:0]  dsack_s;
    logic        err_q, timeout;

    cd32_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_bg (
        .clk(CLKCPU_A), .rst_n(RESET_N), .d(BG_N), .q(bg_s));
    cd32_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_as20 (
        .clk(CLKCPU_A), .rst_n(RESET_N), .d(AS20_N), .q(as20_s));
    cd32_sync #(.WIDTH(2), .STAGES(SYNC_STAGES)) u_sync_dsack (
        .clk(CLKCPU_A), .rst_n(RESET_N), .d(DSACK_N), .q(dsack_s));

    always_ff @(posedge CLKCPU_A) begin
        if (!RESET_N) begin
            state     <= IDLE;
            rw_q      <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            RDATA     <= '0;
            setup_cnt <= '0;
        end else begin
            state     <= state_nxt;
            setup_cnt <= (state == ADDR) ? setup_cnt + 2'd1 : 2'd0;
            if (state == IDLE && REQ) begin
                rw_q    <= REQ_RW;
                addr_q  <= REQ_ADDR;
                wdata_q <= REQ_WDATA;
            end
            // LATCH is only reached via a real DSACK, so a timeout leaves RDATA alone.
            if (state == LATCH && rw_q) RDATA <= D;
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] to_cnt;

    // DSACK is checked ahead of this in WAIT, so a same-cycle ack wins.
    assign timeout = (state == WAIT) && (to_cnt == TIMEOUT_LAST);

    always_ff @(posedge CLKCPU_A) begin
        if (!RESET_N) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            to_cnt <= (state == WAIT) ? to_cnt + 8'd1 : 8'd0;
            if (state == IDLE && REQ)                  err_q <= 1'b0;
            else if (timeout && dsack_s == DSACK_NONE) err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err_q   = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (REQ) state_nxt = ARB;
            ARB:     if (!bg_s && as20_s) state_nxt = ADDR;
            ADDR:    if (setup_cnt == SETUP_LAST) state_nxt = STROBE;
            STROBE:  state_nxt = WAIT;
            WAIT:    if (dsack_s != DSACK_NONE) state_nxt = LATCH;
                     else if (timeout)          state_nxt = RELEASE;
            LATCH:   state_nxt = RELEASE;
            RELEASE: if (dsack_s == DSACK_NONE || err_q) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        BUSY     = (state != IDLE) && (state != FINISH);
        DONE     = (state == FINISH);
        ERR      = DONE && err_q;
        BR_N     = (state != ARB);
        BUS_OE   = is_master(state);
        BGACK_N  = !BUS_OE;
        AS_OUT_N = !(state inside {STROBE, WAIT, LATCH});
        DS_OUT_N = AS_OUT_N;
        RW_OUT   = BUS_OE ? rw_q : 1'b1;
        A_OUT    = BUS_OE ? addr_q : 24'h0;
        d_oe     = !rw_q && (state inside {ADDR, STROBE, WAIT, LATCH});
    end

    assign D = d_oe ? wdata_q : 8'hzz;

endmodule

// File: doc/cd32_bus_initiator.md
Name: cd32_bus_initiator

Overview:
- Initiator side of the 68020 asynchronous byte bus cycle on the CD32 riser. The existing riser logic only terminates cycles with DSACK.
- Takes a single-byte read or write request from riser-internal logic (the SPI command front end) and arbitrates for the bus with BR/BG/BGACK.
- Drives AS/DS/RW/A/D[31:24], waits for DSACK termination, then returns read data and status to the requester.
- Lets the MCU reach Amiga-side registers, for example RTC/CIA at $DCxxxx, without the CPU.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the BG_N and DSACK_N input synchronisers (range 2..3).
- TIMEOUT_CYCLES, 255, CLKCPU_A cycles allowed in WAIT before a bus-error abort (used only with BUS_TIMEOUT_EN).
- SETUP_CYCLES, 1, cycles address/RW/data are driven before AS_N asserts (range 1..3).

Ports:
- CLKCPU_A  input  1  sole clock, all state on rising edge.
- RESET_N  input  1  synchronous, active-low reset.
- REQ  input  1  request strobe; sampled only in IDLE.
- REQ_RW  input  1  1 = read, 0 = write.
- REQ_ADDR  input  24  byte address.
- REQ_WDATA  input  8  write data.
- BUSY  output  1  high from request acceptance until the DONE cycle.
- DONE  output  1  one-cycle completion pulse.
- ERR  output  1  valid with DONE; 1 = timeout abort.
- RDATA  output  8  read data, held until next acceptance.
- BR_N  output  1  bus request, active low.
- BG_N  input  1  bus grant, active low, asynchronous.
- BGACK_N  output  1  bus grant acknowledge, active low.
- AS20_N  input  1  bus address strobe, monitored for bus-idle.
- AS_OUT_N  output  1  address strobe, active low.
- DS_OUT_N  output  1  data strobe, active low.
- RW_OUT  output  1  bus read/write.
- A_OUT  output  24  bus address.
- D  inout  8  D[31:24] lane; driven only when writing as master.
- BUS_OE  output  1  1 = A_OUT/RW_OUT/strobes driven; external tristate enable.
- DSACK_N  input  2  cycle termination, active low, asynchronous.

Behaviour:
- Reset (RESET_N low at an edge):
  - BR_N, BGACK_N, AS_OUT_N and DS_OUT_N = 1.
  - RW_OUT = 1; A_OUT = 0; RDATA = 0.
  - BUSY, DONE, ERR and BUS_OE = 0; D tristated.
  - State returns to IDLE.
  - This applies equally mid-cycle: strobes negate and the bus is released at that edge, and no DONE is issued.
- Synchronisation: BG_N, AS20_N and DSACK_N pass through SYNC_STAGES flops before any decision. D is sampled raw, but only in LATCH.
- IDLE:
  - REQ=1 captures REQ_RW, REQ_ADDR and REQ_WDATA, sets BUSY, and moves to ARB.
  - REQ while BUSY is ignored, with no queueing.
- ARB: BR_N=0. Wait for synced BG_N=0 and synced AS20_N=1, then go to ADDR.
- ADDR:
  - BGACK_N=0, BR_N=1, BUS_OE=1; A_OUT and RW_OUT driven.
  - On writes, D is driven with the captured data.
  - Stay SETUP_CYCLES cycles, then go to STROBE.
- STROBE: AS_OUT_N=0 and DS_OUT_N=0 (both in the same cycle), then go to WAIT.
- WAIT:
  - Any synced DSACK_N != 2'b11 goes to LATCH.
  - 8/16/32-bit port acks are all accepted; the byte is always on D[31:24].
- LATCH: on reads, RDATA <= D. Next state is RELEASE.
- RELEASE:
  - AS_OUT_N=1 and DS_OUT_N=1; D tristated.
  - Wait for synced DSACK_N=2'b11, then go to FINISH.
- FINISH:
  - DONE=1 for one cycle; ERR as set.
  - BGACK_N=1, BUS_OE=0, BUSY=0.
  - Return to IDLE. REQ is honoured no earlier than the next cycle.
- Latency:
  - Accept to STROBE = 1 + arbitration + SETUP_CYCLES.
  - A write never drives D when BUS_OE=0.
- Simultaneous events:
  - If DSACK returns in the same cycle as a timeout, DSACK wins and ERR=0.
  - If BG_N is withdrawn during ARB before AS20 goes idle, remain in ARB.

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- When defined:
  - An 8-bit counter clears on entry to WAIT.
  - When it reaches TIMEOUT_CYCLES without DSACK, go straight to RELEASE with ERR=1.
  - RDATA is left unchanged.
  - RELEASE does not wait for DSACK negation after a timeout.
- When undefined: WAIT is unbounded, ERR is tied to 0, and no counter logic is present.

Decomposition:
- Shared package cd32_bus_pkg:
  - state enum (IDLE, ARB, ADDR, STROBE, WAIT, LATCH, RELEASE, FINISH);
  - DSACK encodings (DSACK_NONE=2'b11, DSACK_BYTE=2'b10);
  - RTC base constant 8'hDC.
- One sub-module, cd32_sync (parameterised-width multi-stage synchroniser), instantiated for BG_N, AS20_N and DSACK_N.

Test Plan:
- Read with immediate grant, REQ_ADDR=24'hDC0004, responder returns DSACK_N=2'b10 with D=8'h5A after 3 cycles -> RW_OUT=1, A_OUT=DC0004, RDATA=8'h5A, DONE one cycle, ERR=0, BUS_OE=0 afterwards.
- Write of 8'hA5 to 24'hDC0010 -> D=8'hA5 is driven from ADDR through LATCH only; RW_OUT=0 before AS_OUT_N falls; D is tristated in RELEASE.
- Grant held off: BG_N=1 for 20 cycles, then BG_N=0 while AS20_N=0 for 4 more cycles -> BR_N low throughout, no BGACK_N or strobes until AS20_N=1 is seen synced.
- With BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16 and no DSACK -> strobes negate 16 cycles after WAIT entry, DONE and ERR both 1, RDATA unchanged.
- RESET_N pulsed low during WAIT -> at that edge AS_OUT_N=1, BGACK_N=1, BUS_OE=0, BUSY=0, no DONE; the next REQ completes normally.
- REQ asserted continuously across a transaction -> exactly one transaction per IDLE visit; the second starts the cycle after DONE.
